// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic valid/ready register chain with stall and flush
module pipe_stage_chain #(
    parameter int                 WIDTH     = 32,
    parameter int                 STAGES    = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          stall,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OW = $clog2(STAGES + 1);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipe_stage_chain: STAGES must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d     [STAGES];
    logic [STAGES-1:0] r;
    logic [STAGES-1:0] up_v;
    logic [WIDTH-1:0]  up_d  [STAGES];
    logic              go;
    logic              tail_full;

    assign go = !stall && !flush && !rst;

    // A slot may advance when any slot at or below it is empty, or the sink takes the tail.
    always_comb begin
        r         = '0;
        tail_full = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            tail_full = tail_full & v[i];
            r[i]      = !tail_full || out_ready;
        end
    end

    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                if (r[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OW'(v[i]);
        end
    end

    assign in_ready  = r[0] && go;
    assign out_valid = v[STAGES-1] && go;
    assign out_data  = d[STAGES-1];

endmodule
